// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with trap, return, debug halt and misaligned-target handling
module pc_sequencer #(
    parameter int                  WORDSIZE    = 32,
    parameter logic [WORDSIZE-1:0] PC_INIT_VAL = 32'h0000_0000,
    parameter logic [WORDSIZE-1:0] TRAP_VEC    = 32'h0000_0100
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                fetch_ready,
    input  logic                stall,
    input  logic                pc_src,
    input  logic [WORDSIZE-1:0] imm_ext,
    input  logic                jalr,
    input  logic [WORDSIZE-1:0] rs1_val,
    input  logic                trap,
    input  logic                mret,
    input  logic                halt,
    input  logic                resume,
    output logic [WORDSIZE-1:0] PC,
    output logic                pc_valid,
    output logic [WORDSIZE-1:0] epc,
    output logic                redirect,
    output logic                misaligned,
    output logic                halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seqState_t;

    seqState_t           state;
    logic                inTrap;
    logic [WORDSIZE-1:0] seqPc;
    logic [WORDSIZE-1:0] jalrTarget;
    logic [WORDSIZE-1:0] branchTarget;
    logic [WORDSIZE-1:0] jumpTarget;
    logic                jumpReq;
    logic                jumpMisaligned;
    logic                takeMret;

    // Candidate next-PC values; all sums wrap at the word width
    always_comb begin
        seqPc          = PC + WORDSIZE'(4);
        jalrTarget     = (rs1_val + imm_ext) & ~WORDSIZE'(1);
        branchTarget   = PC + imm_ext;
        jumpTarget     = jalr ? jalrTarget : branchTarget;
        jumpReq        = jalr | pc_src;
        jumpMisaligned = jumpReq && (jumpTarget[1:0] != 2'b00);
        takeMret       = mret && inTrap;
    end

    // Sequencer FSM: BOOT holds the init PC one cycle, RUN selects the next PC, HALT freezes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= BOOT;
            PC         <= PC_INIT_VAL;
            epc        <= '0;
            inTrap     <= 1'b0;
            pc_valid   <= 1'b0;
            redirect   <= 1'b0;
            misaligned <= 1'b0;
            halted     <= 1'b0;
        end else begin
            redirect   <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                BOOT: begin
                    state    <= RUN;
                    PC       <= PC_INIT_VAL;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (halt) begin
                        state    <= HALT;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end else if (trap || (!takeMret && jumpMisaligned)) begin
                        if (inTrap) begin
                            // Double fault: freeze PC and epc for the debugger
                            state    <= HALT;
                            pc_valid <= 1'b0;
                            halted   <= 1'b1;
                        end else begin
                            PC         <= TRAP_VEC;
                            epc        <= PC;
                            inTrap     <= 1'b1;
                            redirect   <= 1'b1;
                            misaligned <= !trap;
                        end
                    end else if (takeMret) begin
                        PC       <= epc;
                        inTrap   <= 1'b0;
                        redirect <= 1'b1;
                    end else if (jumpReq) begin
                        PC       <= jumpTarget;
                        redirect <= 1'b1;
                    end else if (fetch_ready && !stall) begin
                        PC <= seqPc;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                        halted   <= 1'b0;
                        inTrap   <= 1'b0;
                    end
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - table-driven scoreboard bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk;
    logic        reset_n;
    logic        fetch_ready;
    logic        stall;
    logic        pc_src;
    logic [31:0] imm_ext;
    logic        jalr;
    logic [31:0] rs1_val;
    logic        trap;
    logic        mret;
    logic        halt;
    logic        resume;
    logic [31:0] PC;
    logic        pc_valid;
    logic [31:0] epc;
    logic        redirect;
    logic        misaligned;
    logic        halted;

    pc_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fetch_ready(fetch_ready),
        .stall      (stall),
        .pc_src     (pc_src),
        .imm_ext    (imm_ext),
        .jalr       (jalr),
        .rs1_val    (rs1_val),
        .trap       (trap),
        .mret       (mret),
        .halt       (halt),
        .resume     (resume),
        .PC         (PC),
        .pc_valid   (pc_valid),
        .epc        (epc),
        .redirect   (redirect),
        .misaligned (misaligned),
        .halted     (halted)
    );

    typedef struct {
        logic        fr;
        logic        st;
        logic        ps;
        logic [31:0] imm;
        logic        jr;
        logic [31:0] rs1;
        logic        tr;
        logic        mr;
        logic        hl;
        logic        rs;
        logic [31:0] ePc;
        logic        eValid;
        logic        eRedirect;
        logic        eMis;
        logic        eHalted;
        logic [31:0] eEpc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic fr, input logic st, input logic ps, input logic [31:0] imm,
                       input logic jr, input logic [31:0] rs1, input logic tr, input logic mr,
                       input logic hl, input logic rs, input logic [31:0] ePc, input logic eValid,
                       input logic eRedirect, input logic eMis, input logic eHalted,
                       input logic [31:0] eEpc);
        vec_t v;
        v.fr = fr; v.st = st; v.ps = ps; v.imm = imm; v.jr = jr; v.rs1 = rs1;
        v.tr = tr; v.mr = mr; v.hl = hl; v.rs = rs;
        v.ePc = ePc; v.eValid = eValid; v.eRedirect = eRedirect; v.eMis = eMis;
        v.eHalted = eHalted; v.eEpc = eEpc;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        fetch_ready = 1'b1; stall = 1'b0; pc_src = 1'b0; imm_ext = '0; jalr = 1'b0;
        rs1_val = '0; trap = 1'b0; mret = 1'b0; halt = 1'b0; resume = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        check({tag, ".PC"}, PC, e.ePc);
        check({tag, ".pc_valid"}, {31'b0, pc_valid}, {31'b0, e.eValid});
        check({tag, ".redirect"}, {31'b0, redirect}, {31'b0, e.eRedirect});
        check({tag, ".misaligned"}, {31'b0, misaligned}, {31'b0, e.eMis});
        check({tag, ".halted"}, {31'b0, halted}, {31'b0, e.eHalted});
        check({tag, ".epc"}, epc, e.eEpc);
    endtask

    // Drive one record just after an edge, clock it in, then score the result
    task automatic step(input int idx);
        vec_t v;
        vec_t e;
        v = vecs[idx];
        fetch_ready = v.fr; stall = v.st; pc_src = v.ps; imm_ext = v.imm; jalr = v.jr;
        rs1_val = v.rs1; trap = v.tr; mret = v.mr; halt = v.hl; resume = v.rs;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: empty queue at row %0d", idx);
        end else begin
            e = sb.pop_front();
            check_outputs($sformatf("row%0d", idx), e);
        end
    endtask

    vec_t ref_v;

    initial begin
        //  fr st ps imm           jr rs1           tr mr hl rs | PC            val rd mis hlt epc
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0000_0000, 1, 0, 0, 0, 32'h0);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0000_0004, 1, 0, 0, 0, 32'h0);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0000_0008, 1, 0, 0, 0, 32'h0);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0000_000C, 1, 0, 0, 0, 32'h0);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0000_0010, 1, 0, 0, 0, 32'h0);
        add(1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0000_0010, 1, 0, 0, 0, 32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0000_0010, 1, 0, 0, 0, 32'h0);
        add(0, 1, 1, 32'hFFFF_FFF8, 0, 32'h0,       0, 0, 0, 0,  32'h0000_0008, 1, 1, 0, 0, 32'h0);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0000_000C, 1, 0, 0, 0, 32'h0);
        add(1, 0, 0, 32'h2,        1, 32'h201,      0, 0, 0, 0,  32'h0000_0100, 1, 1, 1, 0, 32'hC);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  32'h0000_000C, 1, 1, 0, 0, 32'hC);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0000_0010, 1, 0, 0, 0, 32'hC);
        add(1, 0, 0, 32'h35,       1, 32'h1000,     0, 0, 0, 0,  32'h0000_1034, 1, 1, 0, 0, 32'hC);
        add(1, 0, 1, 32'hFFFF_F00C, 0, 32'h0,       0, 0, 0, 0,  32'h0000_0040, 1, 1, 0, 0, 32'hC);
        add(1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0,  32'h0000_0100, 1, 1, 0, 0, 32'h40);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0000_0104, 1, 0, 0, 0, 32'h40);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  32'h0000_0040, 1, 1, 0, 0, 32'h40);
        add(1, 0, 1, 32'h8,        0, 32'h0,        0, 1, 0, 0,  32'h0000_0048, 1, 1, 0, 0, 32'h40);
        add(1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0,  32'h0000_0100, 1, 1, 0, 0, 32'h48);
        add(1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0,  32'h0000_0100, 0, 0, 0, 1, 32'h48);
        add(1, 0, 1, 32'h8,        0, 32'h0,        1, 0, 0, 0,  32'h0000_0100, 0, 0, 0, 1, 32'h48);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1,  32'h0000_0100, 1, 0, 0, 0, 32'h48);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0000_0104, 1, 0, 0, 0, 32'h48);
        add(1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0,  32'h0000_0100, 1, 1, 0, 0, 32'h104);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  32'h0000_0104, 1, 1, 0, 0, 32'h104);
        add(1, 0, 1, 32'hFFFF_FF1C, 0, 32'h0,       0, 0, 0, 0,  32'h0000_0020, 1, 1, 0, 0, 32'h104);
        add(1, 0, 1, 32'h4,        0, 32'h0,        1, 1, 0, 0,  32'h0000_0100, 1, 1, 0, 0, 32'h20);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  32'h0000_0020, 1, 1, 0, 0, 32'h20);
        add(1, 0, 1, 32'hFFFF_FFDC, 0, 32'h0,       0, 0, 0, 0,  32'hFFFF_FFFC, 1, 1, 0, 0, 32'h20);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0000_0000, 1, 0, 0, 0, 32'h20);
        add(1, 0, 1, 32'h2,        0, 32'h0,        0, 0, 0, 0,  32'h0000_0100, 1, 1, 1, 0, 32'h0);
        add(1, 0, 1, 32'h6,        0, 32'h0,        0, 0, 0, 0,  32'h0000_0100, 0, 0, 0, 1, 32'h0);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1,  32'h0000_0100, 1, 0, 0, 0, 32'h0);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1,  32'h0000_0104, 1, 0, 0, 0, 32'h0);
        add(1, 0, 1, 32'h8,        0, 32'h0,        1, 0, 1, 0,  32'h0000_0104, 0, 0, 0, 1, 32'h0);

        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ref_v.ePc = 32'h0; ref_v.eValid = 1'b0; ref_v.eRedirect = 1'b0;
        ref_v.eMis = 1'b0; ref_v.eHalted = 1'b0; ref_v.eEpc = 32'h0;
        check_outputs("reset", ref_v);
        reset_n = 1'b1;
        #1;
        check_outputs("boot", ref_v);

        for (int i = 0; i < vecs.size(); i++) step(i);

        // Asynchronous reset in the middle of HALT, well away from any edge
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs("async_reset", ref_v);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_outputs("boot_after_halt", ref_v);
        @(posedge clk);
        #1;
        ref_v.eValid = 1'b1;
        check_outputs("first_fetch", ref_v);
        @(posedge clk);
        #1;
        ref_v.ePc = 32'h4;
        check_outputs("second_fetch", ref_v);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter WORDSIZE, default 32, meaning the width of the PC and all address operands.
REQ-002 The block SHALL have parameter PC_INIT_VAL, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-003 The block SHALL have parameter TRAP_VEC, default 32'h0000_0100, meaning the trap handler entry address.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port fetch_ready, input, 1 bit, meaning instruction memory accepts PC this cycle.
REQ-007 The block SHALL have port stall, input, 1 bit, meaning hold PC (pipeline hazard).
REQ-008 The block SHALL have port pc_src, input, 1 bit, meaning branch-taken AND zero, or JAL.
REQ-009 The block SHALL have port imm_ext, input, WORDSIZE bits, the immediate-generator output.
REQ-010 The block SHALL have port jalr, input, 1 bit, meaning register-indirect jump.
REQ-011 The block SHALL have port rs1_val, input, WORDSIZE bits, the JALR base register value.
REQ-012 The block SHALL have port trap, input, 1 bit, meaning synchronous exception request.
REQ-013 The block SHALL have port mret, input, 1 bit, meaning return from trap.
REQ-014 The block SHALL have port halt, input, 1 bit, and port resume, input, 1 bit, for debug halt and release.
REQ-015 The block SHALL have port PC, output, WORDSIZE bits, the current fetch address (registered).
REQ-016 The block SHALL have port pc_valid, output, 1 bit, meaning PC is a valid fetch request.
REQ-017 The block SHALL have port epc, output, WORDSIZE bits, the saved exception PC (registered).
REQ-018 The block SHALL have port redirect, output, 1 bit, a one-cycle pulse when PC was loaded non-sequentially (flush).
REQ-019 The block SHALL have port misaligned, output, 1 bit, a one-cycle pulse on a misaligned-target trap.
REQ-020 The block SHALL have port halted, output, 1 bit, meaning the FSM is in HALT.

Function
REQ-021 The FSM SHALL have states BOOT, RUN and HALT; pc_valid = 1 only in RUN; halted = 1 only in HALT.
REQ-022 In BOOT, the FSM SHALL hold PC = PC_INIT_VAL for exactly one cycle, then go to RUN.
REQ-023 In RUN, the next PC SHALL be chosen by fixed priority: trap > mret > jalr > pc_src > sequential.
REQ-024 Arithmetic: the trap target SHALL be TRAP_VEC; the mret target SHALL be epc.
REQ-025 Arithmetic: the jalr target SHALL be (rs1_val + imm_ext) with bit0 cleared.
REQ-026 Arithmetic: the pc_src target SHALL be PC + imm_ext; sequential SHALL be PC + 4.
REQ-027 All sums SHALL be modulo 2^WORDSIZE (wrap-around, no carry out).
REQ-028 Sequential advance SHALL occur only when fetch_ready = 1 and stall = 0; otherwise PC SHALL hold.
REQ-029 Redirects (trap, mret, jalr, pc_src) SHALL take effect on the next edge regardless of stall or fetch_ready.
REQ-030 redirect SHALL pulse in the cycle after any redirect is applied.
REQ-031 A jalr or pc_src target with bits[1:0] != 0 SHALL instead load TRAP_VEC, set epc = current PC, pulse misaligned and pulse redirect.
REQ-032 On trap, epc SHALL load the current PC and the internal in_trap flag SHALL set.
REQ-033 mret SHALL clear in_trap; mret with in_trap = 0 SHALL be ignored (lower-priority selection applies).
REQ-034 A trap or misaligned event while in_trap = 1 (double fault) SHALL move the FSM to HALT with PC unchanged and epc unchanged.
REQ-035 halt = 1 in RUN SHALL move the FSM to HALT with PC held; halt SHALL have priority over all redirects.
REQ-036 In HALT, all control inputs except resume SHALL be ignored.
REQ-037 resume = 1 in HALT SHALL return the FSM to RUN with in_trap cleared; PC SHALL resume from its held value.
REQ-038 resume outside HALT SHALL be ignored.

Reset
REQ-039 reset_n = 0 SHALL immediately, without a clock, force state BOOT, PC = PC_INIT_VAL, epc = 0, in_trap = 0, pc_valid = 0, redirect = 0, misaligned = 0, halted = 0.
REQ-040 Reset asserted mid-operation, including in HALT or in a trap, SHALL abandon all state; the first valid fetch after release SHALL be PC_INIT_VAL, one cycle after the BOOT cycle.

Verification
REQ-041 Bench: release reset, fetch_ready = 1 held -> PC sequence 0 (pc_valid = 0), 0, 4, 8, 12.
REQ-042 Bench: at PC = 0x10, pc_src = 1, imm_ext = 0xFFFF_FFF8 -> PC = 0x08 next cycle, redirect pulse; with stall = 1 instead and no redirect -> PC stays 0x10.
REQ-043 Bench: jalr = 1, rs1_val = 0x201, imm_ext = 0x2 -> PC = 0x202 is misaligned -> PC = 0x100, epc = current PC, misaligned = 1 for one cycle.
REQ-044 Bench: trap at PC = 0x40 -> PC = 0x100, epc = 0x40; mret -> PC = 0x40; trap again in handler before mret -> halted = 1, PC frozen.
REQ-045 Bench: trap, mret and pc_src asserted together at PC = 0x20 -> trap wins, PC = 0x100; PC = 0xFFFF_FFFC sequential -> PC = 0x0.
REQ-046 Bench: halt in RUN, then pulse reset_n low mid-HALT -> PC = PC_INIT_VAL asynchronously, BOOT, then RUN.
